// File: rtl/mau_arbiter_if.sv
// Requester-side and MAU-side signal bundle for mau_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the MAU.
interface mau_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ*2-1:0]  req_op;
  logic [NUM_REQ-1:0]    ack;
  logic [DW-1:0]         rsp_data;
  logic                  busy;
  logic [IW-1:0]         grant_idx;
  logic [AW-1:0]         mau_addr;
  logic [DW-1:0]         mau_data_in;
  logic [1:0]            mau_op;
  logic [DW-1:0]         mau_data_out;

  modport slave (
    input  req, req_addr, req_data, req_op, mau_data_out,
    output ack, rsp_data, busy, grant_idx, mau_addr, mau_data_in, mau_op
  );

  modport master (
    output req, req_addr, req_data, req_op, mau_data_out,
    input  ack, rsp_data, busy, grant_idx, mau_addr, mau_data_in, mau_op
  );
endinterface

// File: rtl/mau_arbiter.sv
// Round-robin arbiter sharing one memory access unit between NUM_REQ requesters.
// Modifying ops are followed by a read-back; every request is answered with the resulting word.
module mau_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mau_arbiter_if.slave    bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  logic [2:0]         state_q,    state_d;
  logic [IW-1:0]      ptr_q,      ptr_d;
  logic [IW-1:0]      grant_q,    grant_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic [NUM_REQ-1:0] ack_q,      ack_d;
  logic [DW-1:0]      rsp_q,      rsp_d;
  logic               busy_q,     busy_d;
  logic [AW-1:0]      mau_addr_q, mau_addr_d;
  logic [DW-1:0]      mau_din_q,  mau_din_d;
  logic [1:0]         mau_op_q,   mau_op_d;

  logic               found_s;
  logic [IW-1:0]      pick_s;
  logic [IW-1:0]      cand_s;
  logic [AW-1:0]      pick_addr_s;
  logic [DW-1:0]      pick_data_s;
  logic [1:0]         pick_op_s;

  // first requesting index at or after the priority pointer, with wrap-around
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found_s && bus.req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // fields of the picked requester
  always_comb begin
    pick_addr_s = '0;
    pick_data_s = '0;
    pick_op_s   = 2'b00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_s == IW'(k)) begin
        pick_addr_s = bus.req_addr[k*AW +: AW];
        pick_data_s = bus.req_data[k*DW +: DW];
        pick_op_s   = bus.req_op[k*2 +: 2];
      end else begin
        pick_op_s   = pick_op_s;
      end
    end
  end

  // sequencer: outputs are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    rsp_d      = rsp_q;
    busy_d     = busy_q;
    mau_addr_d = mau_addr_q;
    mau_din_d  = mau_din_q;
    mau_op_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d    = pick_s;
          busy_d     = 1'b1;
          mau_addr_d = pick_addr_s;
          mau_din_d  = pick_data_s;
          if (pick_op_s == 2'b00) begin
            state_d = S_READ;
          end else begin
            mau_op_d = pick_op_s;
            state_d  = S_OP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OP: begin
        state_d = S_READ;
      end
      S_READ: begin
        cnt_d   = CW'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rsp_d   = bus.mau_data_out;
          ack_d   = NUM_REQ'(1) << grant_q;
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK: begin
        ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rsp_q      <= '0;
      busy_q     <= 1'b0;
      mau_addr_q <= '0;
      mau_din_q  <= '0;
      mau_op_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rsp_q      <= rsp_d;
      busy_q     <= busy_d;
      mau_addr_q <= mau_addr_d;
      mau_din_q  <= mau_din_d;
      mau_op_q   <= mau_op_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rsp_data    = rsp_q;
  assign bus.busy        = busy_q;
  assign bus.grant_idx   = grant_q;
  assign bus.mau_addr    = mau_addr_q;
  assign bus.mau_data_in = mau_din_q;
  assign bus.mau_op      = mau_op_q;

endmodule

// File: tb/tb_mau_arbiter.sv
// Bench for mau_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (latency formulas, round-robin order, reference memory).
module tb_mau_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int RD_LAT  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mau_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  mau_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // MAU stand-in: ops take effect at the clock edge, reads return after RD_LAT cycles
  logic [DW-1:0] mau_mem [16] = '{default: '0};
  logic [DW-1:0] rd_pipe [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    case (bus.mau_op)
      2'b01:   mau_mem[bus.mau_addr[3:0]] <= bus.mau_data_in;
      2'b10:   mau_mem[bus.mau_addr[3:0]] <= mau_mem[bus.mau_addr[3:0]] + bus.mau_data_in;
      2'b11:   mau_mem[bus.mau_addr[3:0]] <= mau_mem[bus.mau_addr[3:0]] - bus.mau_data_in;
      default: ;
    endcase
    rd_pipe[0] <= mau_mem[bus.mau_addr[3:0]];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mau_data_out = rd_pipe[RD_LAT-1];

  // reference model state
  logic [DW-1:0] mem_ref [16] = '{default: '0};
  int            cyc      = 0;
  int            busy_end = -1;
  int            gcyc     = -10;
  int            ptr      = 0;
  int            g        = 0;
  logic [1:0]    gop      = 2'b00;
  logic [AW-1:0] gaddr    = '0;
  logic [DW-1:0] gdata    = '0;
  logic [DW-1:0] exp_rsp  = '0;
  logic [DW-1:0] last_rsp = '0;
  bit            sticky  [NUM_REQ];
  bit            reraise [NUM_REQ];
  int            dut_acks[NUM_REQ];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] op);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
    bus.req_op[i*2 +: 2]     = op;
    bus.req[i]               = 1'b1;
  endtask

  // decide at the end of an idle cycle who is served and what it will return
  task automatic arbitrate();
    if (cyc > busy_end) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i = (ptr + k) % NUM_REQ;
        if (bus.req[i]) begin
          g     = i;
          gcyc  = cyc;
          gop   = bus.req_op[i*2 +: 2];
          gaddr = bus.req_addr[i*AW +: AW];
          gdata = bus.req_data[i*DW +: DW];
          case (gop)
            2'b01:   mem_ref[gaddr[3:0]] = gdata;
            2'b10:   mem_ref[gaddr[3:0]] = mem_ref[gaddr[3:0]] + gdata;
            2'b11:   mem_ref[gaddr[3:0]] = mem_ref[gaddr[3:0]] - gdata;
            default: ;
          endcase
          exp_rsp  = mem_ref[gaddr[3:0]];
          busy_end = cyc + ((gop == 2'b00) ? RD_LAT + 2 : RD_LAT + 3);
          ptr      = (g + 1) % NUM_REQ;
          break;
        end
      end
    end
  endtask

  task automatic step();
    logic [63:0] exp_ack;
    arbitrate();
    @(posedge clk);
    #1;
    cyc++;
    exp_ack = (cyc == busy_end) ? (64'd1 << g) : 64'd0;
    if (cyc == busy_end) last_rsp = exp_rsp;
    check_eq("busy", {63'd0, bus.busy}, {63'd0, (cyc <= busy_end)});
    check_eq("ack", {60'd0, bus.ack}, exp_ack);
    check_eq("rsp_data", {32'd0, bus.rsp_data}, {32'd0, last_rsp});
    check_eq("mau_op", {62'd0, bus.mau_op}, (cyc == gcyc + 1) ? {62'd0, gop} : 64'd0);
    if (cyc > gcyc && cyc <= busy_end)
      check_eq("grant_idx", {62'd0, bus.grant_idx}, g);
    if (cyc > gcyc && cyc < busy_end)
      check_eq("mau_addr", {32'd0, bus.mau_addr}, {32'd0, gaddr});
    if (cyc == gcyc + 1 && gop != 2'b00)
      check_eq("mau_data_in", {32'd0, bus.mau_data_in}, {32'd0, gdata});
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.ack[i]) dut_acks[i]++;
      if (reraise[i]) begin
        bus.req[i] = 1'b1;
        reraise[i] = 1'b0;
      end
    end
    if (cyc == busy_end) begin
      bus.req[g] = 1'b0;
      if (sticky[g]) reraise[g] = 1'b1;
    end
  endtask

  function automatic bit any_reraise();
    bit r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r = r | reraise[i];
    return r;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((bus.req != '0 || cyc <= busy_end || any_reraise()) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_timeout", {63'd0, (n < budget)}, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ack", {60'd0, bus.ack}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_rsp", {32'd0, bus.rsp_data}, 64'd0);
    check_eq("rst_grant", {62'd0, bus.grant_idx}, 64'd0);
    check_eq("rst_mau_addr", {32'd0, bus.mau_addr}, 64'd0);
    check_eq("rst_mau_din", {32'd0, bus.mau_data_in}, 64'd0);
    check_eq("rst_mau_op", {62'd0, bus.mau_op}, 64'd0);
    bus.req  = '0;
    ptr      = 0;
    busy_end = -1;
    gcyc     = -10;
    gop      = 2'b00;
    last_rsp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sticky[i]  = 1'b0;
      reraise[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    int before1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_op   = '0;
    for (int i = 0; i < NUM_REQ; i++) dut_acks[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    post(0, 32'd10, 32'hABCD, 2'b01);
    drain(50);
    post(1, 32'd10, 32'h1234, 2'b01); drain(50);
    post(1, 32'd10, 32'h1234, 2'b10); drain(50);
    post(1, 32'd10, 32'h1234, 2'b11); drain(50);
    post(1, 32'd10, 32'h0,    2'b00); drain(50);

    // simultaneous requests after reset are served 0,1,2
    do_reset();
    post(0, 32'd1, 32'h1111, 2'b01);
    post(1, 32'd2, 32'h2222, 2'b01);
    post(2, 32'd3, 32'h3333, 2'b01);
    drain(100);

    // requesters 0 and 2 keep asking; they must alternate
    before1 = dut_acks[1];
    sticky[0] = 1'b1;
    sticky[2] = 1'b1;
    post(0, 32'd4, 32'h40, 2'b10);
    post(2, 32'd6, 32'h60, 2'b01);
    repeat (6 * (RD_LAT + 5)) step();
    sticky[0] = 1'b0;
    sticky[2] = 1'b0;
    drain(100);
    check_eq("req1_never_acked", dut_acks[1] - before1, 64'd0);

    // abandon a read with reset during WAIT; pointer returns to 0
    post(0, 32'd7, 32'h77, 2'b01);
    drain(50);
    post(3, 32'd5, 32'h0, 2'b00);
    for (int n = 0; n < 20 && !(cyc == gcyc + 2 && cyc <= busy_end); n++) step();
    check_eq("reached_wait", {63'd0, (cyc == gcyc + 2)}, 64'd1);
    do_reset();
    repeat (RD_LAT + 3) step();
    post(2, 32'd8, 32'h88, 2'b01);
    post(0, 32'd9, 32'h99, 2'b01);
    drain(100);

    // add on a location holding 7
    post(0, 32'd5, 32'd7, 2'b01); drain(50);
    post(0, 32'd5, 32'd5, 2'b10); drain(50);
    check_eq("add_5_plus_7", {32'd0, bus.rsp_data}, 64'd12);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 99) < 35) begin
        int i = $urandom_range(0, NUM_REQ - 1);
        if (!bus.req[i])
          post(i, 32'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
      end
    end
    drain(400);

    for (int a = 0; a < 16; a++)
      check_eq("mem_contents", {32'd0, mau_mem[a]}, {32'd0, mem_ref[a]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
